// File: rtl/adma_pkg.sv
// Shared ADMA2 descriptor field layout and responder state encoding.
// Imported by the descriptor memory responder and its storage array.
package adma_pkg;

  localparam int ADMA_DESC_W = 64;

  localparam int ATTR_VALID  = 0;
  localparam int ATTR_END    = 1;
  localparam int ATTR_INT    = 2;
  localparam int ATTR_ACT_LO = 4;
  localparam int ATTR_ACT_HI = 5;

  localparam int DESC_ADDR_LO = 32;
  localparam int DESC_ADDR_HI = 63;
  localparam int DESC_LEN_LO  = 16;
  localparam int DESC_LEN_HI  = 31;
  localparam int DESC_ATTR_LO = 0;
  localparam int DESC_ATTR_HI = 15;

  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } adma_act_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } rsp_state_e;

  function automatic adma_act_e desc_act(
    input logic [ADMA_DESC_W-1:0] d
  );
    return adma_act_e'(d[ATTR_ACT_HI:ATTR_ACT_LO]);
  endfunction

endpackage

// File: rtl/adma_desc_mem_array.sv
// Descriptor storage: one synchronous write port, one registered read port.
// The read register can be cleared so error responses return zero data.
module adma_desc_mem_array
  import adma_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_index,
  input  logic [ADMA_DESC_W-1:0]   wr_data,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  input  logic [$clog2(DEPTH)-1:0] rd_index,
  output logic [ADMA_DESC_W-1:0]   rd_data
);

  logic [ADMA_DESC_W-1:0] mem_q [DEPTH];
  logic [ADMA_DESC_W-1:0] rdata_q, rdata_d;

  // Storage is intentionally not reset; tables are preloaded by the host.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_index] <= wr_data;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr)     rdata_d = '0;
    else if (rd_en) rdata_d = mem_q[rd_index];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rd_data = rdata_q;

endmodule

// File: rtl/adma_desc_mem_responder.sv
// System-memory responder for ADMA descriptor fetches (4-phase enb/ack).
// ADMA_DESC_MEM_STATS_EN adds saturating read/error counters.
module adma_desc_mem_responder
  import adma_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0000_1000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enb_rd,
  input  logic [63:0]              rd_addr,
  output logic                     ack_rd,
  output logic [ADMA_DESC_W-1:0]   rd_data,
  output logic                     rd_error,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_index,
  input  logic [ADMA_DESC_W-1:0]   wr_data
`ifdef ADMA_DESC_MEM_STATS_EN
  ,
  output logic [15:0]              rd_count,
  output logic [15:0]              err_count
`endif
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES - 1);

  rsp_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        cap;
  logic        addr_ok;
  logic [63:0] addr_sel;
  logic [IW-1:0] rd_idx;

  // In IDLE the live address is checked so a zero-wait read can capture at once.
  assign addr_sel = (state_q == S_IDLE) ? rd_addr : addr_q;
  assign addr_ok  = (addr_sel[2:0] == 3'd0)
                 && (addr_sel >= BASE_ADDR)
                 && (addr_sel <  END_ADDR);
  assign rd_idx   = IW'((addr_sel - BASE_ADDR) >> 3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ack_d   = ack_q;
    err_d   = err_q;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enb_rd) begin
          addr_d = rd_addr;
          if (WAIT_CYCLES == 0) begin
            cap = 1'b1;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) cap = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      S_ACK, S_RELEASE: begin
        if (!enb_rd) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cap) begin
      state_d = S_ACK;
      ack_d   = 1'b1;
      err_d   = ~addr_ok;
    end
  end

`ifdef ADMA_DESC_MEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cap && rd_cnt_q != 16'hFFFF)
      rd_cnt_d = rd_cnt_q + 16'd1;
    if (cap && !addr_ok && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_count  = rd_cnt_q;
  assign err_count = err_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  adma_desc_mem_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_data  (wr_data),
    .rd_en    (cap & addr_ok),
    .rd_clr   (cap & ~addr_ok),
    .rd_index (rd_idx),
    .rd_data  (rd_data)
  );

  assign ack_rd   = ack_q;
  assign rd_error = err_q;

endmodule

// File: tb/tb_adma_desc_mem_responder.sv
// Bench for adma_desc_mem_responder: vector table, corner sequences,
// and randomized reads checked against an address/memory reference model.
module tb_adma_desc_mem_responder;

  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h0000_0000_0000_1000;
  localparam int          WAITC = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enb_rd = 1'b0;
  logic [63:0] rd_addr = '0;
  logic        ack_rd;
  logic [63:0] rd_data;
  logic        rd_error;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_index = '0;
  logic [63:0] wr_data = '0;
`ifdef ADMA_DESC_MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] err_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int st_rd  = 0;
  int st_err = 0;
  logic [63:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  adma_desc_mem_responder #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enb_rd   (enb_rd),
    .rd_addr  (rd_addr),
    .ack_rd   (ack_rd),
    .rd_data  (rd_data),
    .rd_error (rd_error),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_data  (wr_data)
`ifdef ADMA_DESC_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .err_count(err_count)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int          hold;
    logic        err;
    logic [63:0] data;
  } vec_t;

  vec_t tbl [8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {63'd0, act}, {63'd0, exp});
  endtask

  function automatic logic ref_ok(input logic [63:0] a);
    return (a % 64'd8 == 64'd0) && (a >= BASE)
        && (a < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  function automatic logic [63:0] ref_data(input logic [63:0] a);
    if (!ref_ok(a)) return 64'd0;
    return ref_mem[int'((a - BASE) / 64'd8)];
  endfunction

  task automatic wr(input int idx, input logic [63:0] d);
    wr_en = 1'b1;
    wr_index = 4'(idx);
    wr_data = d;
    cyc();
    wr_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  // wr_cyc > 0 drives a write to the read's own entry into edge number wr_cyc
  task automatic do_read(input logic [63:0] a, input int hold,
                         input logic e_err, input logic [63:0] e_data,
                         input int wr_cyc, input logic [63:0] wdat);
    int n;
    enb_rd = 1'b1;
    rd_addr = a;
    for (n = 1; n <= 40; n++) begin
      if (n == wr_cyc) begin
        wr_en = 1'b1;
        wr_index = 4'((a - BASE) >> 3);
        wr_data = wdat;
      end
      cyc();
      wr_en = 1'b0;
      if (n == 1) rd_addr = ~a;
      if (ack_rd) break;
    end
    chk("ack_latency", 64'(n), 64'(WAITC + 1));
    if (ack_rd !== 1'b1) begin
      enb_rd = 1'b0;
      cyc();
      return;
    end
    st_rd++;
    if (e_err) st_err++;
    chk1("rd_error", rd_error, e_err);
    chk("rd_data", rd_data, e_data);
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk1("hold_ack", ack_rd, 1'b1);
      chk("hold_data", rd_data, e_data);
    end
    enb_rd = 1'b0;
    cyc();
    chk1("rel_ack", ack_rd, 1'b0);
    chk1("rel_err", rd_error, 1'b0);
    chk("rel_data", rd_data, e_data);
  endtask

  task automatic check_stats(input string nm, input int r, input int e);
`ifdef ADMA_DESC_MEM_STATS_EN
    chk({nm, "_rd_count"}, 64'(rd_count), 64'(r));
    chk({nm, "_err_count"}, 64'(err_count), 64'(e));
`else
    if (nm.len() < 0) $display("%0d %0d", r, e);
`endif
  endtask

  task automatic quiet_after_reset(input string nm);
    int acks;
    enb_rd = 1'b0;
    cyc();
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < WAITC + 4; i++) begin
      cyc();
      if (ack_rd) acks++;
    end
    chk(nm, 64'(acks), 64'd0);
  endtask

  initial begin
    logic [63:0] old_d;
    logic [63:0] a;
    int k;
    int wc;

    tbl[0] = '{64'h1000, 5, 1'b0, 64'h0000_2000_0200_0023};
    tbl[1] = '{64'h1004, 0, 1'b1, 64'h0};
    tbl[2] = '{64'h0FF8, 0, 1'b1, 64'h0};
    tbl[3] = '{64'h1080, 0, 1'b1, 64'h0};
    tbl[4] = '{64'h1078, 1, 1'b0, 64'h0000_F000_0010_0031};
    tbl[5] = '{64'h0F80, 0, 1'b1, 64'h0};
    tbl[6] = '{64'h1_0000_1000, 0, 1'b1, 64'h0};
    tbl[7] = '{64'h1040, 2, 1'b0, 64'h1234_5678_9ABC_0012};

    cyc();
    cyc();
    chk1("reset_ack", ack_rd, 1'b0);
    chk1("reset_err", rd_error, 1'b0);
    chk("reset_data", rd_data, 64'd0);
    reset_n = 1'b1;
    cyc();

    for (int i = 0; i < DEPTH; i++) wr(i, {$urandom, $urandom});
    wr(0, 64'h0000_2000_0200_0023);
    wr(15, 64'h0000_F000_0010_0031);
    wr(8, 64'h1234_5678_9ABC_0012);

    for (int i = 0; i < 8; i++)
      do_read(tbl[i].addr, tbl[i].hold, tbl[i].err, tbl[i].data, 0, 64'd0);

    // write on the capture edge is not seen; the next read sees it
    old_d = ref_mem[3];
    do_read(BASE + 64'd24, 0, 1'b0, old_d, WAITC + 1, 64'hAAAA_0000_5555_0001);
    ref_mem[3] = 64'hAAAA_0000_5555_0001;
    do_read(BASE + 64'd24, 0, 1'b0, ref_mem[3], 0, 64'd0);
    if (WAITC > 0) begin
      do_read(BASE + 64'd24, 0, 1'b0, 64'hBBBB_1111_2222_0013,
              WAITC, 64'hBBBB_1111_2222_0013);
      ref_mem[3] = 64'hBBBB_1111_2222_0013;
    end

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        wr($urandom_range(0, DEPTH - 1), {$urandom, $urandom});
      k = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 3))
        0, 1: a = BASE + 64'(k) * 64'd8;
        2: a = BASE + 64'(k) * 64'd8 + 64'($urandom_range(1, 7));
        default: a = {$urandom, $urandom};
      endcase
      wc = ref_ok(a) ? int'($urandom_range(0, WAITC + 1)) : 0;
      if (wc != 0 && wc <= WAITC) begin
        ref_mem[k] = {$urandom, $urandom};
        do_read(a, int'($urandom_range(0, 3)), 1'b0, ref_mem[k],
                wc, ref_mem[k]);
      end else if (wc != 0) begin
        old_d = ref_data(a);
        do_read(a, int'($urandom_range(0, 3)), 1'b0, old_d,
                wc, 64'hC0DE_0000_0000_0000 | 64'(i));
        ref_mem[k] = 64'hC0DE_0000_0000_0000 | 64'(i);
      end else begin
        do_read(a, int'($urandom_range(0, 3)), !ref_ok(a), ref_data(a),
                0, 64'd0);
      end
    end

    check_stats("pre_reset", st_rd, st_err);

    // reset while acknowledging clears outputs immediately
    enb_rd = 1'b1;
    rd_addr = BASE + 64'd8;
    for (int n = 0; n < 40 && !ack_rd; n++) cyc();
    chk1("ack_before_reset", ack_rd, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("reset_rel_ack", ack_rd, 1'b0);
    chk1("reset_rel_err", rd_error, 1'b0);
    chk("reset_rel_data", rd_data, 64'd0);
    check_stats("reset_rel", 0, 0);
    quiet_after_reset("no_ack_after_rel_reset");

    // reset during wait states aborts the request
    enb_rd = 1'b1;
    rd_addr = BASE;
    cyc();
    reset_n = 1'b0;
    #1;
    chk1("reset_wait_ack", ack_rd, 1'b0);
    quiet_after_reset("no_ack_after_wait_reset");

    st_rd = 0;
    st_err = 0;
    do_read(BASE, 0, 1'b0, ref_mem[0], 0, 64'd0);
    do_read(BASE + 64'd4, 0, 1'b1, 64'd0, 0, 64'd0);
    do_read(BASE + 64'h78, 0, 1'b0, ref_mem[15], 0, 64'd0);
    check_stats("three_reads", st_rd, st_err);
    reset_n = 1'b0;
    #1;
    check_stats("after_reset", 0, 0);
    reset_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
